// File: rtl/baccarat_pkg.sv
// ----------------------------------------------------------------------------
// baccarat_pkg
// Shared types and constants for the baccarat round controller.
//   state_t       : FSM state encoding (RST, P1, D1, P2, D2, EVAL, P3, D3, RES)
//   NATURAL_MIN   : a two-card score at or above this ends the round at once
//   PLAYER_DRAW_MAX : highest score at which a hand still takes a third card
//   card_value()  : card rank (0 = none, 1..13 = A..K) -> baccarat value 0..9
// ----------------------------------------------------------------------------
package baccarat_pkg;

    typedef enum logic [3:0] {
        RST  = 4'd0,
        P1   = 4'd1,
        D1   = 4'd2,
        P2   = 4'd3,
        D2   = 4'd4,
        EVAL = 4'd5,
        P3   = 4'd6,
        D3   = 4'd7,
        RES  = 4'd8
    } state_t;

    localparam logic [3:0] NATURAL_MIN     = 4'd8;
    localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;

    // Tens and face cards count zero; an absent card (rank 0) also counts zero.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        if (rank >= 4'd10) begin
            return 4'd0;
        end
        return rank;
    endfunction

endpackage

// File: rtl/baccarat_banker_rule.sv
// ----------------------------------------------------------------------------
// baccarat_banker_rule
// Combinational banker third-card decision.
//   dscore      in  4  banker two-card score, 0..9
//   v           in  4  value of the player's third card, 0..9
//   player_drew in  1  player took a third card (v is meaningful)
//   banker_draw out 1  banker takes a third card
// When the player stood, the banker draws on the same threshold as the player.
// ----------------------------------------------------------------------------
module baccarat_banker_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] v,
    input  logic       player_drew,
    output logic       banker_draw
);

    always_comb begin
        // NOTE: default assignment first so no path leaves banker_draw unassigned (no latch).
        banker_draw = 1'b0;
        if (!player_drew) begin
            banker_draw = (dscore <= PLAYER_DRAW_MAX);
        end else begin
            case (dscore)
                4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
                4'd3:             banker_draw = (v != 4'd8);
                4'd4:             banker_draw = (v >= 4'd2) && (v <= 4'd7);
                4'd5:             banker_draw = (v >= 4'd4) && (v <= 4'd7);
                4'd6:             banker_draw = (v >= 4'd6) && (v <= 4'd7);
                default:          banker_draw = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/baccarat_fsm.sv
// ----------------------------------------------------------------------------
// baccarat_fsm
// Round controller sitting directly upstream of the card datapath. Steps
// through the deal order one state per slow_clock cycle, applies the natural,
// player-draw and banker-draw rules, and latches the round result until reset.
//   slow_clock   in   1  rising-edge clock shared with the datapath
//   resetb       in   1  synchronous, active-high reset
//   pcard3_in    in   4  player third-card rank (0 = none, 1..13)
//   pscore_in    in   4  player hand score 0..9
//   dscore_in    in   4  dealer hand score 0..9
//   load_pcard1..3, load_dcard1..3  out  one-cycle card load strobes
//   player_win, dealer_win          out  round result (both high = tie)
//   round_done                      out  result valid
// Optional macro BACCARAT_TALLY_EN adds saturating win/tie tallies
//   player_tally, dealer_tally, tie_tally [TALLY_W-1:0], cleared by resetb.
// ----------------------------------------------------------------------------
module baccarat_fsm
    import baccarat_pkg::*;
`ifdef BACCARAT_TALLY_EN
#(
    parameter int TALLY_W = 8
)
`endif
(
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic [3:0]         pcard3_in,
    input  logic [3:0]         pscore_in,
    input  logic [3:0]         dscore_in,
    output logic               load_pcard1,
    output logic               load_pcard2,
    output logic               load_pcard3,
    output logic               load_dcard1,
    output logic               load_dcard2,
    output logic               load_dcard3,
    output logic               player_win,
    output logic               dealer_win,
`ifdef BACCARAT_TALLY_EN
    output logic [TALLY_W-1:0] player_tally,
    output logic [TALLY_W-1:0] dealer_tally,
    output logic [TALLY_W-1:0] tie_tally,
`endif
    output logic               round_done
);

    state_t     state;
    state_t     next_state;
    logic       banker_draw;
    logic       is_natural;
    logic       enter_res;

    // In EVAL the player has not drawn, so the rule reduces to the plain
    // threshold; in P3 the third card value drives the table.
    baccarat_banker_rule u_banker_rule (
        .dscore      (dscore_in),
        .v           (card_value(pcard3_in)),
        .player_drew (state == P3),
        .banker_draw (banker_draw)
    );

    assign is_natural = (pscore_in >= NATURAL_MIN) || (dscore_in >= NATURAL_MIN);

    always_comb begin
        next_state = state;
        case (state)
            RST:  next_state = P1;
            P1:   next_state = D1;
            D1:   next_state = P2;
            P2:   next_state = D2;
            D2:   next_state = EVAL;
            EVAL: begin
                if (is_natural) begin
                    next_state = RES;
                end else if (pscore_in <= PLAYER_DRAW_MAX) begin
                    next_state = P3;
                end else if (banker_draw) begin
                    next_state = D3;
                end else begin
                    next_state = RES;
                end
            end
            P3:      next_state = banker_draw ? D3 : RES;
            D3:      next_state = RES;
            RES:     next_state = RES;
            default: next_state = RST;
        endcase
    end

    assign enter_res = (next_state == RES) && (state != RES);

    // NOTE: reset is a synchronous, active-high input sampled on the clock edge, not an async clear.
    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            state      <= RST;
            player_win <= 1'b0;
            dealer_win <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values.
            state <= next_state;
            if (enter_res) begin
                player_win <= (pscore_in >= dscore_in);
                dealer_win <= (dscore_in >= pscore_in);
            end
        end
    end

`ifdef BACCARAT_TALLY_EN
    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            player_tally <= '0;
            dealer_tally <= '0;
            tie_tally    <= '0;
        end else if (enter_res) begin
            if (pscore_in > dscore_in) begin
                if (player_tally != '1) player_tally <= player_tally + 1'b1;
            end else if (dscore_in > pscore_in) begin
                if (dealer_tally != '1) dealer_tally <= dealer_tally + 1'b1;
            end else begin
                if (tie_tally != '1) tie_tally <= tie_tally + 1'b1;
            end
        end
    end
`endif

    // Moore decode: strobes and done depend only on the current state.
    assign load_pcard1 = (state == P1);
    assign load_dcard1 = (state == D1);
    assign load_pcard2 = (state == P2);
    assign load_dcard2 = (state == D2);
    assign load_pcard3 = (state == P3);
    assign load_dcard3 = (state == D3);
    assign round_done  = (state == RES);

endmodule

// File: tb/tb_baccarat_fsm.sv
// ----------------------------------------------------------------------------
// tb_baccarat_fsm
// Self-checking bench for baccarat_fsm. The bench plays the datapath: it
// presents two-card scores up front, and when it sees a third-card strobe it
// presents the rank and the updated hand score. A rule-level reference model
// predicts the strobe sequence, round length and result.
// ----------------------------------------------------------------------------
module tb_baccarat_fsm;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b1;
    logic [3:0] pcard3_in  = 4'd0;
    logic [3:0] pscore_in  = 4'd0;
    logic [3:0] dscore_in  = 4'd0;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win, dealer_win, round_done;
`ifdef BACCARAT_TALLY_EN
    logic [7:0] player_tally, dealer_tally, tie_tally;
    int         m_pt, m_dt, m_tt;
`endif

    logic [8:0] outs;
    logic [5:0] strobes;
    assign strobes = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};
    assign outs    = {round_done, dealer_win, player_win, strobes};

    int total = 0;
    int bad   = 0;

    baccarat_fsm dut (
        .slow_clock   (slow_clock),
        .resetb       (resetb),
        .pcard3_in    (pcard3_in),
        .pscore_in    (pscore_in),
        .dscore_in    (dscore_in),
        .load_pcard1  (load_pcard1),
        .load_pcard2  (load_pcard2),
        .load_pcard3  (load_pcard3),
        .load_dcard1  (load_dcard1),
        .load_dcard2  (load_dcard2),
        .load_dcard3  (load_dcard3),
        .player_win   (player_win),
        .dealer_win   (dealer_win),
`ifdef BACCARAT_TALLY_EN
        .player_tally (player_tally),
        .dealer_tally (dealer_tally),
        .tie_tally    (tie_tally),
`endif
        .round_done   (round_done)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Baccarat card value from rank: only ace..nine carry points.
    function automatic int rank_value(input int rank);
        return (rank >= 1 && rank <= 9) ? rank : 0;
    endfunction

    // Banker drawing table as a bitmask of third-card values per banker score.
    function automatic bit banker_draws(input int d, input int v);
        logic [9:0] mask;
        case (d)
            0, 1, 2: mask = 10'h3FF;
            3:       mask = 10'h2FF;
            4:       mask = 10'h0FC;
            5:       mask = 10'h0F0;
            6:       mask = 10'h0C0;
            default: mask = 10'h000;
        endcase
        return mask[v];
    endfunction

`ifdef BACCARAT_TALLY_EN
    task automatic check_tally(input string tag);
        check({tag, "/ptally"}, player_tally, m_pt);
        check({tag, "/dtally"}, dealer_tally, m_dt);
        check({tag, "/ttally"}, tie_tally, m_tt);
    endtask
`endif

    // Play one complete round from reset. p0/d0 are two-card scores; rank is
    // the player third card; pf/df the hand scores after a third card.
    task automatic run_round(input string name, input int p0, input int d0,
                             input int rank, input int pf, input int df);
        int exp_seq[$];
        int fp, fd;
        int exp_code, obs_code, done_k, early_win;
        exp_seq   = '{1, 2, 3, 4};
        fp        = p0;
        fd        = d0;
        exp_code  = 0;
        obs_code  = 0;
        done_k    = -1;
        early_win = 0;
        if (!(p0 >= 8 || d0 >= 8)) begin
            if (p0 <= 5) begin
                exp_seq.push_back(5);
                fp = pf;
                if (banker_draws(d0, rank_value(rank))) begin
                    exp_seq.push_back(6);
                    fd = df;
                end
            end else if (d0 <= 5) begin
                exp_seq.push_back(6);
                fd = df;
            end
        end
        foreach (exp_seq[i]) exp_code = exp_code * 8 + exp_seq[i];

        resetb    = 1'b1;
        pscore_in = 4'(p0);
        dscore_in = 4'(d0);
        pcard3_in = 4'd0;
        @(posedge slow_clock);
        #1;
        check({name, "/reset_outs"}, outs, 0);
`ifdef BACCARAT_TALLY_EN
        m_pt = 0; m_dt = 0; m_tt = 0;
        check_tally({name, "/reset"});
`endif
        resetb = 1'b0;

        for (int k = 1; k <= 20; k++) begin
            @(posedge slow_clock);
            #1;
            check({name, "/onehot"}, ($countones(strobes) <= 1), 1);
            if (!round_done && (player_win || dealer_win)) early_win++;
            for (int j = 0; j < 6; j++) begin
                if (strobes[j]) obs_code = obs_code * 8 + j + 1;
            end
            if (load_pcard3) begin
                pcard3_in = 4'(rank);
                pscore_in = 4'(pf);
            end
            if (load_dcard3) dscore_in = 4'(df);
            if (round_done) begin
                done_k = k;
                break;
            end
        end

        check({name, "/sequence"}, obs_code, exp_code);
        check({name, "/done_cycle"}, done_k, 2 + exp_seq.size());
        check({name, "/early_win"}, early_win, 0);
        check({name, "/player_win"}, player_win, (fp >= fd));
        check({name, "/dealer_win"}, dealer_win, (fd >= fp));
`ifdef BACCARAT_TALLY_EN
        if (fp > fd)      m_pt = (m_pt < 255) ? m_pt + 1 : 255;
        else if (fd > fp) m_dt = (m_dt < 255) ? m_dt + 1 : 255;
        else              m_tt = (m_tt < 255) ? m_tt + 1 : 255;
        check_tally(name);
`endif

        // Result must stay frozen whatever the datapath does afterwards.
        for (int k = 0; k < 2; k++) begin
            pscore_in = 4'($urandom_range(0, 9));
            dscore_in = 4'($urandom_range(0, 9));
            pcard3_in = 4'($urandom_range(0, 13));
            @(posedge slow_clock);
            #1;
            check({name, "/frozen"}, outs, {1'b1, 1'(fd >= fp), 1'(fp >= fd), 6'b0});
        end
`ifdef BACCARAT_TALLY_EN
        check_tally({name, "/frozen"});
`endif
    endtask

    initial begin
        // Directed scenarios.
        run_round("natural_p8_d3", 8, 3, 0, 0, 0);
        run_round("p4_d6_v7",      4, 6, 7, 1, 9);
        run_round("p2_d3_v8",      2, 3, 8, 0, 0);
        run_round("p7_d5_stand",   7, 5, 0, 0, 7);
        run_round("natural_d9",    3, 9, 0, 0, 0);
        run_round("p6_d6_stand",   6, 6, 0, 0, 0);
        run_round("p0_d3_king",    0, 3, 13, 5, 4);
        run_round("p5_d7_draw",    5, 7, 6, 2, 1);

        // Reset mid-deal: assert during P2, outputs clear, deal restarts at P1.
        resetb = 1'b1;
        pscore_in = 4'd4;
        dscore_in = 4'd4;
        @(posedge slow_clock);
        #1;
        resetb = 1'b0;
        repeat (3) @(posedge slow_clock);
        #1;
        check("midreset/in_p2", outs, 9'b0_0000_0100);
        resetb = 1'b1;
        @(posedge slow_clock);
        #1;
        check("midreset/cleared", outs, 0);
        resetb = 1'b0;
        @(posedge slow_clock);
        #1;
        check("midreset/restart_p1", outs, 9'b0_0000_0001);
        @(posedge slow_clock);
        #1;
        check("midreset/then_d1", outs, 9'b0_0000_0010);

        // Randomized rounds, including the illegal absent third card (rank 0).
        for (int n = 0; n < 40; n++) begin
            run_round("random",
                      int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                      int'($urandom_range(0, 13)),
                      int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
